// File: rtl/flexio_shifter.sv
// flexio_shifter: NUM_CH independent serial shift channels (TX or RX) sharing a bank of IO_BITS pads,
// configured through a word-addressed register port, with a level interrupt on transfer completion.
module flexio_shifter #(
    parameter int IO_BITS    = 8,
    parameter int NUM_CH     = 4,
    parameter int SHIFT_BITS = 32,
    parameter int DIV_BITS   = 8
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               reg_we,
    input  logic [7:0]         reg_addr,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata,
    input  logic [IO_BITS-1:0] io_in,
    output logic [IO_BITS-1:0] io_out,
    output logic [IO_BITS-1:0] io_oeb,
    output logic               irq
);
    localparam int SB = SHIFT_BITS;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_DIV    = 2'd1;
    localparam logic [1:0] A_DATA   = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    logic [5:0]              w_sel_ch;
    logic [1:0]              w_sel_reg;
    logic [NUM_CH-1:0]       w_drive;
    logic [NUM_CH-1:0]       w_tx_bit;
    logic [NUM_CH-1:0]       w_irq;
    logic [NUM_CH-1:0][3:0]  w_pin;
    logic [31:0]             w_rd [NUM_CH][4];
    logic [IO_BITS-1:0]      w_pad_out;
    logic [IO_BITS-1:0]      w_pad_oeb;
    logic [IO_BITS-1:0]      r_io_out;
    logic [IO_BITS-1:0]      r_io_oeb;

    assign w_sel_ch  = reg_addr[7:2];
    assign w_sel_reg = reg_addr[1:0];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic                r_en;
        logic                r_dir;
        logic                r_msb;
        logic                r_idle;
        logic                r_irq_en;
        logic [3:0]          r_pin;
        logic [4:0]          r_cnt_m1;
        logic [DIV_BITS-1:0] r_div;
        logic [DIV_BITS-1:0] r_cnt;
        logic [SB-1:0]       r_shift;
        logic [5:0]          r_remain;
        logic                r_tx_bit;
        logic                r_done;
        state_t              r_state;

        logic                w_wr;
        logic                w_tick;
        logic                w_last;
        logic                w_rx_bit;
        logic [5:0]          w_count;

        assign w_wr    = reg_we && (w_sel_ch == 6'(c));
        assign w_tick  = (r_cnt == r_div);
        assign w_last  = (r_remain <= 6'd1);
        assign w_count = ({1'b0, r_cnt_m1} >= 6'(SB)) ? 6'(SB) : ({1'b0, r_cnt_m1} + 6'd1);

        // A pin beyond the pad bank samples 0.
        always_comb begin
            w_rx_bit = 1'b0;
            for (int p = 0; p < IO_BITS; p++) begin
                if (r_pin == 4'(p)) w_rx_bit = io_in[p];
            end
        end

        always_ff @(posedge clk) begin
            // NOTE: the shift register is a plain flop bank, so resetting it with the rest costs nothing
            // and keeps DATA reads deterministic after reset.
            if (!rstb) begin
                r_en     <= 1'b0;
                r_dir    <= 1'b0;
                r_msb    <= 1'b0;
                r_idle   <= 1'b0;
                r_irq_en <= 1'b0;
                r_pin    <= '0;
                r_cnt_m1 <= '0;
                r_div    <= '0;
                r_cnt    <= '0;
                r_shift  <= '0;
                r_remain <= '0;
                r_tx_bit <= 1'b0;
                r_done   <= 1'b0;
                r_state  <= S_IDLE;
            end else begin
                if (w_wr && w_sel_reg == A_CTRL) begin
                    r_en     <= reg_wdata[0];
                    r_dir    <= reg_wdata[1];
                    r_msb    <= reg_wdata[2];
                    r_idle   <= reg_wdata[3];
                    r_pin    <= reg_wdata[7:4];
                    r_cnt_m1 <= reg_wdata[12:8];
                    r_irq_en <= reg_wdata[16];
                end
                if (w_wr && w_sel_reg == A_DIV) r_div <= reg_wdata[DIV_BITS-1:0];
                // NOTE: the clear is written before the FSM so a completion in the same cycle overrides it.
                if (w_wr && w_sel_reg == A_STATUS && reg_wdata[1]) r_done <= 1'b0;

                case (r_state)
                    S_IDLE: begin
                        if (w_wr && w_sel_reg == A_DATA) begin
                            r_shift <= reg_wdata[SB-1:0];
                            if (r_en) begin
                                r_state  <= S_RUN;
                                r_cnt    <= '0;
                                r_remain <= w_count;
                                r_tx_bit <= r_msb ? reg_wdata[SB-1] : reg_wdata[0];
                            end
                        end
                    end
                    S_RUN: begin
                        if (!r_en) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
                            if (w_tick) begin
                                r_remain <= r_remain - 6'd1;
                                if (r_dir) begin
                                    // The final bit stays in place so DATA shows count-1 shifts.
                                    if (!w_last && r_msb) begin
                                        r_shift  <= {r_shift[SB-2:0], 1'b0};
                                        r_tx_bit <= r_shift[SB-2];
                                    end else if (!w_last) begin
                                        r_shift  <= {1'b0, r_shift[SB-1:1]};
                                        r_tx_bit <= r_shift[1];
                                    end
                                end else if (r_msb) begin
                                    r_shift <= {r_shift[SB-2:0], w_rx_bit};
                                end else begin
                                    r_shift <= {w_rx_bit, r_shift[SB-1:1]};
                                end
                                if (w_last) begin
                                    r_state <= S_IDLE;
                                    r_done  <= 1'b1;
                                end
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end

        assign w_drive[c]  = r_en && r_dir;
        assign w_pin[c]    = r_pin;
        assign w_tx_bit[c] = (r_state == S_RUN) ? r_tx_bit : r_idle;
        assign w_irq[c]    = r_done && r_irq_en;

        assign w_rd[c][0] = {15'd0, r_irq_en, 3'd0, r_cnt_m1, r_pin, r_idle, r_msb, r_dir, r_en};
        assign w_rd[c][1] = 32'(r_div);
        assign w_rd[c][2] = 32'(r_shift);
        assign w_rd[c][3] = {18'd0, r_remain, 6'd0, r_done, (r_state == S_RUN)};
    end

    always_comb begin
        reg_rdata = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_sel_ch == 6'(c)) reg_rdata = w_rd[c][w_sel_reg];
        end
    end

    // Channels are scanned from the top down so the lowest-index owner is the last (winning) assignment.
    always_comb begin
        w_pad_out = '0;
        w_pad_oeb = '1;
        for (int p = 0; p < IO_BITS; p++) begin
            for (int c = NUM_CH - 1; c >= 0; c--) begin
                if (w_drive[c] && w_pin[c] == 4'(p)) begin
                    w_pad_out[p] = w_tx_bit[c];
                    w_pad_oeb[p] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_io_out <= '0;
            r_io_oeb <= '1;
        end else begin
            r_io_out <= w_pad_out;
            r_io_oeb <= w_pad_oeb;
        end
    end

    assign io_out = r_io_out;
    assign io_oeb = r_io_oeb;
    assign irq    = |w_irq;

endmodule

// File: tb/tb_flexio_shifter.sv
// Self-checking bench for flexio_shifter: directed scenarios plus randomized TX/RX transfers
// compared against a bit-level model of each transfer.
module tb_flexio_shifter;
    localparam int IO_BITS = 8;
    localparam int NUM_CH  = 4;

    logic               clk = 1'b0;
    logic               rstb = 1'b0;
    logic               reg_we = 1'b0;
    logic [7:0]         reg_addr = '0;
    logic [31:0]        reg_wdata = '0;
    logic [31:0]        reg_rdata;
    logic [IO_BITS-1:0] io_in = '0;
    logic [IO_BITS-1:0] io_out;
    logic [IO_BITS-1:0] io_oeb;
    logic               irq;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    flexio_shifter #(
        .IO_BITS(IO_BITS), .NUM_CH(NUM_CH), .SHIFT_BITS(32), .DIV_BITS(8)
    ) u_dut (
        .clk(clk), .rstb(rstb), .reg_we(reg_we), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .io_in(io_in),
        .io_out(io_out), .io_oeb(io_oeb), .irq(irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] adr(input int ch, input int r);
        return 8'((ch << 2) | r);
    endfunction

    function automatic logic [31:0] ctrl_word(input bit en, input bit dir, input bit msb, input bit idle,
                                              input int pin, input int cnt, input bit irq_en);
        return 32'(en) | (32'(dir) << 1) | (32'(msb) << 2) | (32'(idle) << 3) |
               (32'(pin) << 4) | (32'(cnt - 1) << 8) | (32'(irq_en) << 16);
    endfunction

    // All stimulus changes and samples happen 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int r, input logic [31:0] d);
        reg_we    = 1'b1;
        reg_addr  = adr(ch, r);
        reg_wdata = d;
        @(posedge clk);
        #1;
        reg_we = 1'b0;
    endtask

    task automatic rd(input int ch, input int r, output logic [31:0] d);
        reg_addr = adr(ch, r);
        #1;
        d = reg_rdata;
    endtask

    task automatic cleanup(input int ch);
        logic [31:0] v;
        wr(ch, 3, 32'h2);
        rd(ch, 3, v);
        check("w1c_clears_done", v & 32'h3, 32'h0);
        check("irq_after_w1c", 32'(irq), 32'h0);
        wr(ch, 0, 32'h0);
    endtask

    // TX transfer; inject_at issues a DATA write at that cycle, w1c_end clears done on the completing edge.
    task automatic run_tx(input int ch, input int pin, input bit msb, input bit idle, input int cnt,
                          input int div, input logic [31:0] data, input int inject_at, input bit w1c_end);
        int          per;
        int          n;
        int          idx;
        int          rem;
        logic [31:0] v;
        logic [31:0] exp_status;
        logic        exp_bit;
        per = div + 1;
        n   = cnt * per;
        wr(ch, 0, ctrl_word(1'b1, 1'b1, msb, idle, pin, cnt, 1'b1));
        wr(ch, 1, 32'(div));
        wr(ch, 2, data);
        for (int c = 1; c <= n; c++) begin
            if (c == inject_at) wr(ch, 2, ~data);
            else if (w1c_end && c == n) wr(ch, 3, 32'h2);
            else tick();
            idx     = (c - 1) / per;
            exp_bit = msb ? data[31 - idx] : data[idx];
            if (pin < IO_BITS) begin
                check("tx_pad_bit", 32'(io_out[pin]), 32'(exp_bit));
                check("tx_pad_oeb", 32'(io_oeb[pin]), 32'h0);
            end else begin
                check("tx_no_pad", 32'(io_oeb), 32'hFF);
            end
            rem        = cnt - c / per;
            exp_status = ((c < n) ? 32'h1 : 32'h2) | (32'(rem) << 8);
            rd(ch, 3, v);
            check("tx_status", v, exp_status);
            check("tx_irq", 32'(irq), (c >= n) ? 32'h1 : 32'h0);
        end
        rd(ch, 2, v);
        check("tx_data_after", v, msb ? (data << (cnt - 1)) : (data >> (cnt - 1)));
        tick();
        if (pin < IO_BITS) begin
            check("tx_idle_level", 32'(io_out[pin]), 32'(idle));
            check("tx_idle_oeb", 32'(io_oeb[pin]), 32'h0);
        end
        cleanup(ch);
    endtask

    // RX transfer; bits[k] is the k-th value presented on the selected pad.
    task automatic run_rx(input int ch, input int pin, input bit msb, input int cnt, input int div,
                          input logic [31:0] data, input logic [31:0] bits);
        logic [31:0] exp;
        logic [31:0] v;
        logic [31:0] rnd;
        logic        b;
        exp = data;
        wr(ch, 0, ctrl_word(1'b1, 1'b0, msb, 1'b0, pin, cnt, 1'b1));
        wr(ch, 1, 32'(div));
        wr(ch, 2, data);
        for (int k = 0; k < cnt; k++) begin
            rnd = $urandom;
            if (pin < IO_BITS) rnd[pin] = bits[k];
            io_in = rnd[IO_BITS-1:0];
            b     = (pin < IO_BITS) ? bits[k] : 1'b0;
            exp   = msb ? ((exp << 1) | 32'(b)) : ((exp >> 1) | (32'(b) << 31));
            if (k == cnt - 1) begin
                repeat (div) tick();
                rd(ch, 3, v);
                check("rx_busy_before_last", v & 32'h3, 32'h1);
                tick();
            end else begin
                repeat (div + 1) tick();
            end
        end
        io_in = '0;
        rd(ch, 3, v);
        check("rx_status_done", v, 32'h2);
        check("rx_irq", 32'(irq), 32'h1);
        rd(ch, 2, v);
        check("rx_data", v, exp);
        cleanup(ch);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] d;

        // Reset state
        repeat (3) tick();
        check("rst_io_out", 32'(io_out), 32'h0);
        check("rst_io_oeb", 32'(io_oeb), 32'hFF);
        check("rst_irq", 32'(irq), 32'h0);
        rd(0, 0, v); check("rst_ctrl", v, 32'h0);
        rd(0, 2, v); check("rst_data", v, 32'h0);
        rd(0, 3, v); check("rst_status", v, 32'h0);
        rstb = 1'b1;
        tick();

        // Register readback masks
        wr(1, 0, 32'hFFFF_FFFF);
        rd(1, 0, v); check("ctrl_mask", v, 32'h0001_1FFF);
        wr(1, 1, 32'hFFFF_FFFF);
        rd(1, 1, v); check("div_mask", v, 32'h0000_00FF);
        wr(1, 0, 32'h0);
        wr(1, 1, 32'h0);

        // TX 0xA5 MSB-first on pad 3, div 1 (byte placed at the top of the 32-bit register)
        run_tx(0, 3, 1'b1, 1'b0, 8, 1, 32'hA500_0000, 0, 1'b0);

        // RX LSB-first on pad 5, div 3, samples 1,1,0,1
        run_rx(1, 5, 1'b0, 4, 3, 32'h0, 32'b1011);
        rd(1, 2, v); check("rx_directed_B0", v, 32'hB000_0000);

        // Pin conflict: ch0 (idle 1) and ch2 (idle 0) both claim pad 0
        wr(0, 0, ctrl_word(1'b1, 1'b1, 1'b0, 1'b1, 0, 8, 1'b0));
        wr(2, 0, ctrl_word(1'b1, 1'b1, 1'b0, 1'b0, 0, 8, 1'b0));
        tick();
        check("conflict_ch0_out", 32'(io_out[0]), 32'h1);
        check("conflict_ch0_oeb", 32'(io_oeb[0]), 32'h0);
        wr(0, 0, 32'h0);
        tick();
        check("handover_ch2_out", 32'(io_out[0]), 32'h0);
        check("handover_ch2_oeb", 32'(io_oeb[0]), 32'h0);
        wr(2, 0, 32'h0);
        tick();
        check("conflict_released", 32'(io_oeb[0]), 32'h1);

        // Abort after 3 ticks of an 8-bit TX with div 1
        d = $urandom;
        wr(0, 0, ctrl_word(1'b1, 1'b1, 1'b1, 1'b0, 3, 8, 1'b1));
        wr(0, 1, 32'd1);
        wr(0, 2, d);
        repeat (6) tick();
        check("abort_pad_driven", 32'(io_oeb[3]), 32'h0);
        wr(0, 0, ctrl_word(1'b0, 1'b1, 1'b1, 1'b0, 3, 8, 1'b1));
        tick();
        rd(0, 3, v);
        check("abort_busy_done", v & 32'h3, 32'h0);
        check("abort_pad_released", 32'(io_oeb[3]), 32'h1);
        check("abort_irq", 32'(irq), 32'h0);
        rd(0, 2, v);
        check("abort_data_kept", v, d << 3);

        // DATA write while busy is ignored; W1C on the completing edge loses to the set
        run_tx(2, 6, 1'b0, 1'b1, 8, 2, $urandom, 5, 1'b0);
        run_tx(3, 1, 1'b1, 1'b0, 5, 0, $urandom, 0, 1'b1);

        // Reset mid-transfer
        wr(0, 0, ctrl_word(1'b1, 1'b1, 1'b1, 1'b1, 2, 16, 1'b1));
        wr(0, 1, 32'd2);
        wr(0, 2, 32'hFFFF_FFFF);
        repeat (5) tick();
        check("pre_reset_oeb", 32'(io_oeb[2]), 32'h0);
        rstb = 1'b0;
        tick();
        check("midrst_io_out", 32'(io_out), 32'h0);
        check("midrst_io_oeb", 32'(io_oeb), 32'hFF);
        check("midrst_irq", 32'(irq), 32'h0);
        rd(0, 0, v); check("midrst_ctrl", v, 32'h0);
        rd(0, 2, v); check("midrst_data", v, 32'h0);
        rd(0, 3, v); check("midrst_status", v, 32'h0);
        rstb = 1'b1;
        tick();

        // Channels beyond NUM_CH
        wr(63, 0, 32'hFFFF_FFFF);
        wr(7, 1, 32'hFFFF_FFFF);
        for (int r = 0; r < 4; r++) begin
            rd(63, r, v); check("ch63_reads_zero", v, 32'h0);
        end
        rd(4, 0, v); check("ch4_reads_zero", v, 32'h0);
        rd(3, 0, v); check("ch63_no_alias_ctrl", v, 32'h0);
        rd(3, 1, v); check("ch7_no_alias_div", v, 32'h0);
        check("ch63_no_pad", 32'(io_oeb), 32'hFF);

        // Randomized transfers
        for (int i = 0; i < 16; i++) begin
            int ch;
            int pin;
            int cnt;
            int div;
            bit msb;
            ch  = $urandom_range(0, NUM_CH - 1);
            pin = $urandom_range(0, 9);
            cnt = $urandom_range(1, 32);
            div = $urandom_range(0, 3);
            msb = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1)
                run_tx(ch, pin, msb, 1'($urandom_range(0, 1)), cnt, div, $urandom, 0, 1'b0);
            else
                run_rx(ch, pin, msb, cnt, div, $urandom, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
